bnn_seq_ctrl: RTL and testbench
===============================

Name: bnn_seq_ctrl

Overview:
- Sequencer in front of the single-layer tiny BNN datapath (8 neurons × 8 binary inputs, serial parameter chain).
- Accepts parameter bytes from a host over valid/ready and serializes them MSB-first onto the chain, keeping setup high only while a bit is actually shifting.
- Then runs inferences: takes an 8-bit input vector, writes it to the datapath as two nibbles (lo bank, then hi bank), and returns the captured 8 axon outputs with a one-cycle valid.

Parameters:
- NEURONS, 8, number of neurons in the parameter chain.
- BITS_PER_NEURON, 12, parameter bits shifted per neuron (weights + bias).
- TOTAL_BITS, NEURONS*BITS_PER_NEURON, chain length (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  pulse: begin a full parameter load.
- cfg_valid  in  1  parameter byte valid.
- cfg_ready  out  1  controller can take a parameter byte.
- cfg_data  in  8  parameter byte, MSB shifted first.
- loaded  out  1  full chain loaded since last reset or cfg_start.
- busy  out  1  state not IDLE/READY.
- x_valid  in  1  input vector valid.
- x_ready  out  1  controller can take an input vector.
- x_data  in  8  input vector; [3:0] lo bank, [7:4] hi bank.
- y_valid  out  1  one-cycle pulse, y_data valid.
- y_data  out  8  captured axon outputs.
- setup  out  1  to datapath setup.
- param_bit  out  1  to datapath param_in.
- x_bank_hi  out  1  to datapath bank select.
- x_nibble  out  4  to datapath x.
- axon  in  8  datapath outputs.
- param_tail  in  1  last neuron param_out.
- rd_valid  out  1  readback byte valid (see Optional Feature).
- rd_data  out  8  readback byte.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Outputs: loaded=0, busy=0, cfg_ready=0, x_ready=0, y_valid=0, y_data=0, setup=0, param_bit=0, x_bank_hi=0, x_nibble=0, rd_valid=0, rd_data=0.
  - Shadow x register = 0; bit counter = 0.
- States: IDLE, LOAD_WAIT, LOAD_SHIFT, READY, WR_LO, WR_HI, SETTLE.
- Datapath hold rule:
  - The datapath latches x_nibble into the selected bank on every edge with setup=0.
  - Therefore, in every state except WR_LO/WR_HI, drive x_bank_hi=0 and x_nibble=shadow[3:0]. This rewrites the unchanged value.
- IDLE:
  - cfg_start → LOAD_WAIT; bit counter cleared.
  - x_ready=0.
- LOAD_WAIT:
  - cfg_ready=1, setup=0.
  - cfg_valid&cfg_ready → shift reg = cfg_data, count8 = min(8, TOTAL_BITS − counter), next state LOAD_SHIFT.
- LOAD_SHIFT:
  - setup=1 and param_bit = shreg[7] for exactly count8 consecutive cycles; shreg shifts left each cycle.
  - Bits beyond TOTAL_BITS in the last byte are discarded (TOTAL_BITS=96 → exactly 12 bytes).
  - After a byte's last bit: counter==TOTAL_BITS → READY with loaded=1; otherwise → LOAD_WAIT.
  - setup is never high in a cycle without a shifted bit.
- READY:
  - x_ready=1.
  - cfg_start has priority: it clears loaded and goes to LOAD_WAIT. A simultaneous x_valid is not accepted.
  - x_valid&x_ready → shadow = x_data, next state WR_LO.
- WR_LO: x_bank_hi=0, x_nibble=shadow[3:0].
- WR_HI: x_bank_hi=1, x_nibble=shadow[7:4].
- SETTLE: at the edge ending SETTLE, y_data <= axon; y_valid=1 for the following cycle; then → READY.
- Latency: x accepted at edge E0 → y_valid high in the cycle after E3 (3-cycle latency). Back-to-back throughput is 1 vector per 4 cycles.
- Conditional behaviour:
  - cfg_start outside IDLE/READY is ignored.
  - x_valid outside READY is not accepted.
  - y_valid has no backpressure.
- busy=1 in LOAD_WAIT, LOAD_SHIFT, WR_LO, WR_HI, SETTLE.
- Reset mid-load: loaded=0; the chain is partially updated and must be fully reloaded.

Optional Feature:
- Macro BNN_READBACK_EN.
- When defined:
  - During each LOAD_SHIFT cycle, param_tail is shifted LSB-in into a capture register.
  - After each byte's last bit: rd_valid pulses for 1 cycle and rd_data = captured bits, first-out bit in MSB. For a short final byte the bits are left-aligned and zero-padded.
  - A second full load therefore returns the previous parameter stream.
- When undefined: rd_valid=0 and rd_data=0 constantly; no capture logic.

Test Plan:
- Reset, then cfg_start with 12 bytes 0xFF, 0x00, ... → exactly 96 setup-high cycles; param_bit matches MSB-first; loaded=1 after last bit; busy=0.
- cfg_valid held low for 5 cycles between bytes → setup=0 and x_bank_hi=0, x_nibble=0 throughout the gap; bit count still 96.
- Loaded, x_data=0xA5 → WR_LO drives nibble 0x5/bank 0, WR_HI drives 0xA/bank 1; model axon=0x3C → y_valid one cycle with y_data=0x3C, 3 cycles after acceptance.
- cfg_start and x_valid same cycle in READY → x not accepted, loaded=0, LOAD_WAIT entered.
- rst_n low mid-byte (bit 4 of byte 6) → all outputs 0 immediately; x_valid afterwards gets x_ready=0.
- BNN_READBACK_EN defined: load stream A, then load stream B → rd_data sequence equals stream A bytes.

Source files
------------

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequencer in front of the tiny single-layer BNN datapath.
// Loads the serial parameter chain from host bytes (MSB first), then runs
// inferences by writing the input vector as two nibbles and capturing axons.
// Optional macro BNN_READBACK_EN: captures the bits falling out of the chain
// tail during a load and returns them as readback bytes.
module bnn_seq_ctrl #(
  parameter int NEURONS         = 8,
  parameter int BITS_PER_NEURON = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cfg_start,
  input  logic       i_cfg_valid,
  output logic       o_cfg_ready,
  input  logic [7:0] i_cfg_data,
  output logic       o_loaded,
  output logic       o_busy,
  input  logic       i_x_valid,
  output logic       o_x_ready,
  input  logic [7:0] i_x_data,
  output logic       o_y_valid,
  output logic [7:0] o_y_data,
  output logic       o_setup,
  output logic       o_param_bit,
  output logic       o_x_bank_hi,
  output logic [3:0] o_x_nibble,
  input  logic [7:0] i_axon,
  input  logic       i_param_tail,
  output logic       o_rd_valid,
  output logic [7:0] o_rd_data
);

  localparam int TOTAL_BITS = NEURONS * BITS_PER_NEURON;
  localparam int CW         = $clog2(TOTAL_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_LOAD_SHIFT,
    S_READY,
    S_WR_LO,
    S_WR_HI,
    S_SETTLE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_bitCnt;
  logic [7:0]      r_shreg;
  logic [3:0]      r_remain;
  logic [7:0]      r_shadow;
  logic            r_cfgReady;
  logic            r_loaded;
  logic            r_busy;
  logic            r_xReady;
  logic            r_yValid;
  logic [7:0]      r_yData;
  logic            r_setup;
  logic            r_paramBit;
  logic            r_xBankHi;
  logic [3:0]      r_xNibble;

  logic [CW-1:0]   w_left;
  logic [3:0]      w_count8;
  logic            w_cfgFire;

  // Bits still missing from the chain decide how many bits of the next byte are used.
  assign w_left    = CW'(TOTAL_BITS) - r_bitCnt;
  assign w_count8  = (w_left >= CW'(8)) ? 4'd8 : w_left[3:0];
  assign w_cfgFire = (r_state == S_LOAD_WAIT) && i_cfg_valid;

  // Main sequencer: state plus every datapath-facing output, all registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_bitCnt   <= '0;
      r_shreg    <= '0;
      r_remain   <= '0;
      r_shadow   <= '0;
      r_cfgReady <= 1'b0;
      r_loaded   <= 1'b0;
      r_busy     <= 1'b0;
      r_xReady   <= 1'b0;
      r_yValid   <= 1'b0;
      r_yData    <= '0;
      r_setup    <= 1'b0;
      r_paramBit <= 1'b0;
      r_xBankHi  <= 1'b0;
      r_xNibble  <= '0;
    end else begin
      r_yValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_start) begin
            r_state    <= S_LOAD_WAIT;
            r_bitCnt   <= '0;
            r_cfgReady <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD_WAIT: begin
          if (w_cfgFire) begin
            r_shreg    <= i_cfg_data;
            r_paramBit <= i_cfg_data[7];
            r_remain   <= w_count8;
            r_setup    <= 1'b1;
            r_cfgReady <= 1'b0;
            r_state    <= S_LOAD_SHIFT;
          end
        end
        S_LOAD_SHIFT: begin
          r_bitCnt <= r_bitCnt + CW'(1);
          r_shreg  <= {r_shreg[6:0], 1'b0};
          r_remain <= r_remain - 4'd1;
          if (r_remain == 4'd1) begin
            r_setup    <= 1'b0;
            r_paramBit <= 1'b0;
            if (r_bitCnt == CW'(TOTAL_BITS - 1)) begin
              r_state  <= S_READY;
              r_loaded <= 1'b1;
              r_busy   <= 1'b0;
              r_xReady <= 1'b1;
            end else begin
              r_state    <= S_LOAD_WAIT;
              r_cfgReady <= 1'b1;
            end
          end else begin
            r_paramBit <= r_shreg[6];
          end
        end
        S_READY: begin
          if (i_cfg_start) begin
            r_state    <= S_LOAD_WAIT;
            r_loaded   <= 1'b0;
            r_bitCnt   <= '0;
            r_cfgReady <= 1'b1;
            r_xReady   <= 1'b0;
            r_busy     <= 1'b1;
          end else if (i_x_valid) begin
            r_shadow  <= i_x_data;
            r_xBankHi <= 1'b0;
            r_xNibble <= i_x_data[3:0];
            r_xReady  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          r_xBankHi <= 1'b1;
          r_xNibble <= r_shadow[7:4];
          r_state   <= S_WR_HI;
        end
        S_WR_HI: begin
          r_xBankHi <= 1'b0;
          r_xNibble <= r_shadow[3:0];
          r_state   <= S_SETTLE;
        end
        S_SETTLE: begin
          r_yData  <= i_axon;
          r_yValid <= 1'b1;
          r_xReady <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_READY;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cfg_ready = r_cfgReady;
  assign o_loaded    = r_loaded;
  assign o_busy      = r_busy;
  assign o_x_ready   = r_xReady;
  assign o_y_valid   = r_yValid;
  assign o_y_data    = r_yData;
  assign o_setup     = r_setup;
  assign o_param_bit = r_paramBit;
  assign o_x_bank_hi = r_xBankHi;
  assign o_x_nibble  = r_xNibble;

`ifdef BNN_READBACK_EN
  logic [7:0] r_cap;
  logic [3:0] r_byteBits;
  logic       r_rdValid;
  logic [7:0] r_rdData;
  logic [7:0] w_capNext;

  assign w_capNext = {r_cap[6:0], i_param_tail};

  // Collect the chain tail while shifting; stale bits fall off the top when left-aligning.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap      <= '0;
      r_byteBits <= '0;
      r_rdValid  <= 1'b0;
      r_rdData   <= '0;
    end else begin
      r_rdValid <= 1'b0;
      if (w_cfgFire) begin
        r_byteBits <= w_count8;
      end
      if (r_state == S_LOAD_SHIFT) begin
        r_cap <= w_capNext;
        if (r_remain == 4'd1) begin
          r_rdValid <= 1'b1;
          r_rdData  <= w_capNext << (4'd8 - r_byteBits);
        end
      end
    end
  end

  assign o_rd_valid = r_rdValid;
  assign o_rd_data  = r_rdData;
`else
  logic w_unusedTail;
  assign w_unusedTail = i_param_tail;
  assign o_rd_valid   = 1'b0;
  assign o_rd_data    = '0;
`endif

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: self-checking bench for bnn_seq_ctrl with a behavioural
// datapath model (96-bit parameter chain, two input banks, axon function).
module tb_bnn_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       cfgStart = 1'b0;
  logic       cfgValid = 1'b0;
  logic [7:0] cfgData = '0;
  logic       xValid = 1'b0;
  logic [7:0] xData = '0;
  logic       cfgReady, loaded, busy, xReady, yValid;
  logic [7:0] yData, rdData, axon;
  logic       setup, paramBit, xBankHi, rdValid, paramTail;
  logic [3:0] xNibble;

  int checks = 0;
  int failures = 0;

  logic [95:0] chain = '0;
  logic [3:0]  bankLo = '0;
  logic [3:0]  bankHi = '0;
  logic [7:0]  axonKey = '0;
  int          setupCycles = 0;
  logic [7:0]  rdLog[$];
  logic [7:0]  curStream[12];
  logic [7:0]  prevStream[12];
  logic [7:0]  lastX = '0;

  always #5 clk = ~clk;

  bnn_seq_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_cfg_start  (cfgStart),
    .i_cfg_valid  (cfgValid),
    .o_cfg_ready  (cfgReady),
    .i_cfg_data   (cfgData),
    .o_loaded     (loaded),
    .o_busy       (busy),
    .i_x_valid    (xValid),
    .o_x_ready    (xReady),
    .i_x_data     (xData),
    .o_y_valid    (yValid),
    .o_y_data     (yData),
    .o_setup      (setup),
    .o_param_bit  (paramBit),
    .o_x_bank_hi  (xBankHi),
    .o_x_nibble   (xNibble),
    .i_axon       (axon),
    .i_param_tail (paramTail),
    .o_rd_valid   (rdValid),
    .o_rd_data    (rdData)
  );

  // Datapath model: chain shifts while setup is high, otherwise the selected bank latches.
  always @(posedge clk) begin
    if (setup) chain <= {chain[94:0], paramBit};
    else if (xBankHi) bankHi <= xNibble;
    else bankLo <= xNibble;
  end

  assign paramTail = chain[95];
  assign axon      = {bankHi, bankLo} ^ axonKey;

  // Count every cycle in which a parameter bit is handed to the chain.
  always @(posedge clk) begin
    if (setup === 1'b1) setupCycles <= setupCycles + 1;
  end

  // Log readback bytes in arrival order.
  always @(posedge clk) begin
    if (rdValid === 1'b1) rdLog.push_back(rdData);
  end

  function automatic logic [31:0] allOutputs();
    return {3'b0, loaded, busy, cfgReady, xReady, yValid, yData, setup,
            paramBit, xBankHi, xNibble, rdValid, rdData};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send one parameter byte over valid/ready; called at a negedge.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    cfgData  = b;
    cfgValid = 1'b1;
    while (cfgReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cfgReadyWait", 32'(n < 100), 32'd1);
    @(negedge clk);
    cfgValid = 1'b0;
  endtask

  task automatic loadStream(input bit withGap);
    int startSetup;
    int n;
    logic [95:0] expChain;
    startSetup = setupCycles;
    cfgStart = 1'b1;
    @(negedge clk);
    cfgStart = 1'b0;
    checkOutput("loadBusy", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (withGap && i == 4) begin
        n = 0;
        while (cfgReady !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (5) begin
          @(negedge clk);
          checkOutput("gapQuiet", {26'b0, setup, xBankHi, xNibble}, {26'b0, 2'b00, lastX[3:0]});
        end
      end
      applyStimulus(curStream[i]);
    end
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loadDoneWait", 32'(n < 50), 32'd1);
    checkOutput("setupCycles", 32'(setupCycles - startSetup), 32'd96);
    expChain = '0;
    for (int i = 0; i < 12; i++) expChain = {expChain[87:0], curStream[i]};
    for (int k = 0; k < 3; k++)
      checkOutput("chainWord", chain[k*32 +: 32], expChain[k*32 +: 32]);
    checkOutput("loadedReady", {28'b0, loaded, busy, xReady, cfgReady}, {28'b0, 4'b1010});
  endtask

  task automatic runInference(input logic [7:0] x, input logic [7:0] key);
    int n;
    int edges;
    axonKey = key;
    xData   = x;
    xValid  = 1'b1;
    n = 0;
    while (xReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("xReadyWait", 32'(n < 50), 32'd1);
    @(negedge clk);
    xValid = 1'b0;
    lastX  = x;
    checkOutput("wrLoDrive", {27'b0, xBankHi, xNibble}, {27'b0, 1'b0, x[3:0]});
    @(negedge clk);
    checkOutput("wrHiDrive", {27'b0, xBankHi, xNibble}, {27'b0, 1'b1, x[7:4]});
    edges = 1;
    while (yValid !== 1'b1 && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'd3);
    checkOutput("yData", {24'b0, yData}, {24'b0, x ^ key});
    checkOutput("banks", {24'b0, bankHi, bankLo}, {24'b0, x});
    @(negedge clk);
    checkOutput("yPulse", 32'(yValid), 32'd0);
  endtask

  initial begin
    int rdStart;
    int startSetup;
    int n;

    #1 rstN = 1'b0;
    #1 checkOutput("resetOutputs", allOutputs(), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    xValid = 1'b1;
    @(negedge clk);
    checkOutput("idleNoAccept", {30'b0, xReady, busy}, 32'd0);
    xValid = 1'b0;

    // First load: directed head bytes, random tail, with a host gap.
    curStream[0] = 8'hFF;
    curStream[1] = 8'h00;
    for (int i = 2; i < 12; i++) curStream[i] = 8'($urandom);
    loadStream(1'b1);

    // Directed inference: x=0xA5 with axon forced to 0x3C.
    runInference(8'hA5, 8'hA5 ^ 8'h3C);
    for (int i = 0; i < 6; i++) runInference(8'($urandom), 8'($urandom));

    // cfg_start and x_valid together in READY: load wins.
    for (int i = 0; i < 12; i++) prevStream[i] = curStream[i];
    rdStart  = rdLog.size();
    cfgStart = 1'b1;
    xValid   = 1'b1;
    xData    = 8'($urandom);
    @(negedge clk);
    cfgStart = 1'b0;
    xValid   = 1'b0;
    checkOutput("collision", {28'b0, loaded, cfgReady, xReady, busy}, {28'b0, 4'b0101});
    repeat (4) begin
      @(negedge clk);
      checkOutput("collisionQuiet", {30'b0, yValid, setup}, 32'd0);
    end

    // Second load (its cfg_start pulse lands in LOAD_WAIT and must be ignored).
    for (int i = 0; i < 12; i++) curStream[i] = 8'($urandom);
    loadStream(1'b0);
`ifdef BNN_READBACK_EN
    checkOutput("rdCount", 32'(rdLog.size() - rdStart), 32'd12);
    for (int i = 0; i < 12; i++)
      if (rdStart + i < rdLog.size())
        checkOutput("rdByte", {24'b0, rdLog[rdStart + i]}, {24'b0, prevStream[i]});
`else
    checkOutput("rdSilent", 32'(rdLog.size() - rdStart), 32'd0);
`endif
    runInference(8'($urandom), 8'($urandom));

    // Reset in the middle of byte 6, while bit 4 is on the wire.
    startSetup = setupCycles;
    cfgStart = 1'b1;
    @(negedge clk);
    cfgStart = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom));
    cfgData  = 8'($urandom);
    cfgValid = 1'b1;
    n = 0;
    while (cfgReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cfgValid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midByteSetup", 32'(setup), 32'd1);
    checkOutput("midByteBits", 32'(setupCycles - startSetup), 32'd52);
    #1 rstN = 1'b0;
    #1 checkOutput("midResetOutputs", allOutputs(), 32'd0);
    @(negedge clk);
    rstN   = 1'b1;
    lastX  = '0;
    xValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("postResetNoX", {29'b0, xReady, loaded, yValid}, 32'd0);
    end
    xValid = 1'b0;

    // Full reload after the interrupted one, then one more inference.
    for (int i = 0; i < 12; i++) curStream[i] = 8'($urandom);
    loadStream(1'b0);
    runInference(8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
